branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor table entries (power of two).
REQ-002 Parameter IDX_W, default 4, index width, equal to log2(ENTRIES).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 lookup_valid  input  1  fetch-side prediction request.
REQ-006 lookup_pc  input  32  PC of the fetched instruction.
REQ-007 pred_valid  output  1  prediction result valid, one cycle after the request.
REQ-008 pred_hit  output  1  table entry valid and tag matched.
REQ-009 pred_taken  output  1  predicted direction.
REQ-010 pred_target  output  32  predicted next PC.
REQ-011 upd_valid  input  1  resolved-branch update from the branch comparator stage.
REQ-012 upd_pc  input  32  PC of the resolved branch.
REQ-013 upd_taken  input  1  resolved direction (comparator branch_taken).
REQ-014 upd_target  input  32  resolved taken target.
REQ-015 upd_ready  output  1  high when updates are accepted; low during table initialisation.

Function
REQ-016 Each entry SHALL hold valid (1b), tag (lookup_pc[31:IDX_W+2]), 2-bit saturating counter, and 32-bit target.
REQ-017 Index SHALL be pc[IDX_W+1:2]; pc[1:0] SHALL be ignored.
REQ-018 FSM states SHALL be INIT and READY; INIT clears one entry per cycle (valid=0, counter=2'b01, target=0), starting at index 0.
REQ-019 INIT SHALL last exactly ENTRIES cycles, then transition to READY; READY SHALL persist until rst.
REQ-020 upd_ready SHALL be 1 only in READY; upd_valid in INIT SHALL be dropped with no state change.
REQ-021 Lookup latency SHALL be one cycle: pred_* registered from the lookup_valid/lookup_pc sampled on the previous edge; pred_valid=0 in a cycle following lookup_valid=0.
REQ-022 Hit: pred_hit=1; pred_taken=counter[1]; pred_target=stored target if pred_taken, else lookup_pc+4.
REQ-023 Miss: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4 (32-bit wrap-around, carry discarded).
REQ-024 Lookups in INIT SHALL be answered as misses.
REQ-025 Update hit (valid and tag match): counter +1 if upd_taken, -1 otherwise, saturating at 2'b11 and 2'b00; target written only when upd_taken=1.
REQ-026 Update miss: entry SHALL be replaced: valid=1, new tag, counter=2'b10 if upd_taken else 2'b01, target=upd_target.
REQ-027 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents (read-before-write).
REQ-028 At most one update per cycle; no back-pressure beyond upd_ready.

Reset
REQ-029 rst high at an edge SHALL force state INIT, init index 0, pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0, upd_ready=0.
REQ-030 rst asserted mid-INIT or mid-operation SHALL restart initialisation from index 0 on the first edge with rst low; prior table contents SHALL never be observable as hits.

Verification
REQ-031 Release rst; hold upd_valid=1 -> upd_ready=0 for exactly 16 cycles, then 1; no table change from dropped updates.
REQ-032 Lookup 0x00000100 after init -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x00000104.
REQ-033 Update pc=0x100 taken target=0x200, then lookup 0x100 -> pred_hit=1, pred_taken=1, pred_target=0x200; three not-taken updates -> counter 00, pred_taken=0, pred_target=0x104; further not-taken updates stay 00.
REQ-034 Alias: update pc=0x100 taken, then update pc=0x140 (same index, different tag) not-taken -> lookup 0x100 misses; lookup 0x140 hits, pred_taken=0.
REQ-035 Same-cycle lookup and miss-update at 0x300 (taken, target 0x400) -> that lookup reports miss; next lookup 0x300 hits, target 0x400.
REQ-036 Lookup 0xFFFFFFFC on miss -> pred_target=0x00000000; rst pulse after training -> all lookups miss after re-init.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped table of tagged 2-bit counters and targets.
// The table is cleared one entry per cycle after reset. Lookups answer one
// cycle later and read the table before any same-cycle update is written.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        upd_ready
);

  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic {INIT, READY} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  init_idx_q, init_idx_d;

  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_d   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [1:0]        ctr_d   [ENTRIES];
  logic [31:0]       tgt_q   [ENTRIES];
  logic [31:0]       tgt_d   [ENTRIES];

  logic              pred_valid_q, pred_valid_d;
  logic              pred_hit_q, pred_hit_d;
  logic              pred_taken_q, pred_taken_d;
  logic [31:0]       pred_target_q, pred_target_d;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, up_hit;

  // The two low PC bits never select anything (word-aligned instructions).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign upd_ready   = (state_q == READY);
  assign pred_valid  = pred_valid_q;
  assign pred_hit    = pred_hit_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;

  // INIT walks every index once, then the predictor stays READY until reset.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + IDX_W'(1);
      if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
        state_d = READY;
      end
    end
  end

  // Lookup reads the current table contents; INIT forces every lookup to miss.
  always_comb begin
    lk_hit        = (state_q == READY) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_valid_d  = lookup_valid;
    pred_hit_d    = 1'b0;
    pred_taken_d  = 1'b0;
    pred_target_d = 32'd0;
    if (lookup_valid) begin
      pred_hit_d    = lk_hit;
      pred_taken_d  = lk_hit && ctr_q[lk_idx][1];
      pred_target_d = (lk_hit && ctr_q[lk_idx][1]) ? tgt_q[lk_idx] : (lookup_pc + 32'd4);
    end
  end

  // Table write: clear during INIT, otherwise train or replace on an update.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    tgt_d   = tgt_q;
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (state_q == INIT) begin
      valid_d[init_idx_q] = 1'b0;
      tag_d[init_idx_q]   = '0;
      ctr_d[init_idx_q]   = 2'b01;
      tgt_d[init_idx_q]   = 32'd0;
    end else if (upd_valid && !rst) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) begin
            ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
          end
          tgt_d[up_idx] = upd_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        ctr_d[up_idx]   = upd_taken ? 2'b10 : 2'b01;
        tgt_d[up_idx]   = upd_target;
      end
    end
  end

  // Control and prediction registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      init_idx_q    <= '0;
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      pred_valid_q  <= pred_valid_d;
      pred_hit_q    <= pred_hit_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  // Table storage; stale contents are hidden by INIT rather than reset here.
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    ctr_q   <= ctr_d;
    tgt_q   <= tgt_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors with a scoreboard queue
// of expected predictions popped by an independent monitor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_ready;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_ready    (upd_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic hit, input logic taken, input logic [31:0] target);
    exp_t e;
    e.hit    = hit;
    e.taken  = taken;
    e.target = target;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; a lookup also records its expected prediction.
  task automatic applyStimulus(input logic lv, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt,
                               input logic ehit, input logic etaken,
                               input logic [31:0] etgt);
    lookup_valid = lv;
    lookup_pc    = lpc;
    upd_valid    = uv;
    upd_pc       = upc;
    upd_taken    = ut;
    upd_target   = utgt;
    if (lv) pushExp(ehit, etaken, etgt);
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    lookup_pc    = 32'd0;
    upd_valid    = 1'b0;
    upd_pc       = 32'd0;
    upd_taken    = 1'b0;
    upd_target   = 32'd0;
  endtask

  task automatic doLookup(input logic [31:0] pc, input logic ehit, input logic etaken,
                          input logic [31:0] etgt);
    applyStimulus(1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, ehit, etaken, etgt);
  endtask

  task automatic doUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    applyStimulus(1'b0, 32'd0, 1'b1, pc, taken, tgt, 1'b0, 1'b0, 32'd0);
  endtask

  // Counts cycles until upd_ready rises, holding whatever inputs are applied.
  // A held lookup during INIT is expected to miss every cycle.
  task automatic countInit(input string name);
    int  cnt;
    logic done;
    cnt  = 0;
    done = 1'b0;
    checkOutput({name, "_ready_low"}, {31'd0, upd_ready}, 32'd0);
    while (!done && cnt < 40) begin
      if (lookup_valid) pushExp(1'b0, 1'b0, lookup_pc + 32'd4);
      @(posedge clk);
      #1;
      cnt++;
      if (upd_ready) done = 1'b1;
    end
    checkOutput({name, "_cycles"}, cnt, 32'd16);
  endtask

  // Monitor: every valid prediction is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pred_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_pred actual=hit%0b taken%0b tgt=%h required=no_output",
                   pred_hit, pred_taken, pred_target);
        end else begin
          e = exp_q.pop_front();
          if (pred_hit !== e.hit || pred_taken !== e.taken || pred_target !== e.target) begin
            failures++;
            $display("[TB] FAIL pred actual=hit%0b taken%0b tgt=%h required=hit%0b taken%0b tgt=%h",
                     pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
          end
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    rst          = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    upd_valid    = 1'b0;
    upd_pc       = 32'd0;
    upd_taken    = 1'b0;
    upd_target   = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
    checkOutput("rst_pred_hit", {31'd0, pred_hit}, 32'd0);
    checkOutput("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    checkOutput("rst_pred_target", pred_target, 32'd0);
    checkOutput("rst_upd_ready", {31'd0, upd_ready}, 32'd0);

    rst        = 1'b0;
    upd_valid  = 1'b1;
    upd_pc     = 32'h100;
    upd_taken  = 1'b1;
    upd_target = 32'h200;
    countInit("init");
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;

    doLookup(32'h100, 1'b0, 1'b0, 32'h104);

    doUpdate(32'h100, 1'b1, 32'h200);
    doLookup(32'h100, 1'b1, 1'b1, 32'h200);
    doUpdate(32'h100, 1'b0, 32'h999);
    doLookup(32'h100, 1'b1, 1'b0, 32'h104);
    doUpdate(32'h100, 1'b0, 32'h999);
    doUpdate(32'h100, 1'b0, 32'h999);
    doLookup(32'h100, 1'b1, 1'b0, 32'h104);
    doUpdate(32'h100, 1'b1, 32'h240);
    doLookup(32'h100, 1'b1, 1'b0, 32'h104);
    doUpdate(32'h100, 1'b1, 32'h260);
    doLookup(32'h100, 1'b1, 1'b1, 32'h260);
    doUpdate(32'h100, 1'b1, 32'h260);
    doUpdate(32'h100, 1'b1, 32'h260);
    doLookup(32'h100, 1'b1, 1'b1, 32'h260);
    doUpdate(32'h100, 1'b0, 32'h999);
    doLookup(32'h100, 1'b1, 1'b1, 32'h260);

    doUpdate(32'h100, 1'b1, 32'h200);
    doUpdate(32'h140, 1'b0, 32'h500);
    doLookup(32'h100, 1'b0, 1'b0, 32'h104);
    doLookup(32'h140, 1'b1, 1'b0, 32'h144);
    doLookup(32'h143, 1'b1, 1'b0, 32'h147);
    doUpdate(32'h140, 1'b1, 32'h540);
    doLookup(32'h140, 1'b1, 1'b1, 32'h540);

    applyStimulus(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 1'b0, 32'h304);
    doLookup(32'h300, 1'b1, 1'b1, 32'h400);

    doUpdate(32'h1008, 1'b1, 32'h2000);
    doLookup(32'h1008, 1'b1, 1'b1, 32'h2000);
    doLookup(32'h104, 1'b0, 1'b0, 32'h108);
    doLookup(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    doLookup(32'h1008, 1'b1, 1'b1, 32'h2000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst2_pred_valid", {31'd0, pred_valid}, 32'd0);
    checkOutput("rst2_pred_target", pred_target, 32'd0);
    checkOutput("rst2_upd_ready", {31'd0, upd_ready}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    countInit("reinit");

    doLookup(32'h300, 1'b0, 1'b0, 32'h304);
    doLookup(32'h1008, 1'b0, 1'b0, 32'h100C);
    doLookup(32'h140, 1'b0, 1'b0, 32'h144);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
